alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_seq.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and flag layout for the sequenced-ALU controller.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned FLAG_W   = 4;
  localparam int unsigned FLAG_C   = 0;
  localparam int unsigned FLAG_Z   = 1;
  localparam int unsigned FLAG_OF  = 2;
  localparam int unsigned FLAG_SOF = 3;

endpackage

// File: rtl/alu_seq.sv
// Accumulator sequencer driving an external combinational ALU through a registered interface.
// Optional sticky overflow flag enabled by defining ALU_SEQ_STICKY_OF_EN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic              cmd_load,
  input  logic              cmd_use_carry,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic [FLAG_W-1:0] res_flags,
  output logic [2:0]        alu_op,
  output logic              alu_in_c,
  output logic [WIDTH-1:0]  alu_in_x,
  output logic [WIDTH-1:0]  alu_in_y,
  input  logic [WIDTH-1:0]  alu_out_s,
  input  logic              alu_out_c,
  input  logic              alu_zero,
  input  logic              alu_overflow
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             of_q, of_d;
  logic [2:0]       op_q, op_d;
  logic             in_c_q, in_c_d;
  logic [WIDTH-1:0] in_x_q, in_x_d;
  logic [WIDTH-1:0] in_y_q, in_y_d;
  logic             sof;

  logic cmd_fire;
  logic res_fire;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign res_fire = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          state_d = cmd_load ? DONE : EXEC;
        end
      end
      EXEC:    state_d = DONE;
      DONE: begin
        if (res_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating on rst keeps the handshakes quiet during the reset cycle itself.
  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      IDLE:    cmd_ready = !rst;
      DONE:    res_valid = !rst;
      default: ;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    c_d    = c_q;
    z_d    = z_q;
    of_d   = of_q;
    op_d   = op_q;
    in_c_d = in_c_q;
    in_x_d = in_x_q;
    in_y_d = in_y_q;
    if (state_q == IDLE && cmd_fire) begin
      if (cmd_load) begin
        acc_d = cmd_data;
      end else begin
        op_d   = cmd_op;
        in_x_d = acc_q;
        in_y_d = cmd_data;
        in_c_d = cmd_use_carry ? c_q : 1'b0;
      end
    end else if (state_q == EXEC) begin
      acc_d = alu_out_s;
      c_d   = alu_out_c;
      z_d   = alu_zero;
      of_d  = alu_overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      of_q   <= 1'b0;
      op_q   <= '0;
      in_c_q <= 1'b0;
      in_x_q <= '0;
      in_y_q <= '0;
    end else begin
      acc_q  <= acc_d;
      c_q    <= c_d;
      z_q    <= z_d;
      of_q   <= of_d;
      op_q   <= op_d;
      in_c_q <= in_c_d;
      in_x_q <= in_x_d;
      in_y_q <= in_y_d;
    end
  end

`ifdef ALU_SEQ_STICKY_OF_EN
  logic sof_q, sof_d;

  always_comb begin
    sof_d = sof_q;
    if (state_q == IDLE && cmd_fire && cmd_load) begin
      sof_d = 1'b0;
    end else if (state_q == EXEC && alu_overflow) begin
      sof_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sof_q <= 1'b0;
    end else begin
      sof_q <= sof_d;
    end
  end

  assign sof = sof_q;
`else
  assign sof = 1'b0;
`endif

  always_comb begin
    res_flags           = '0;
    res_flags[FLAG_C]   = c_q;
    res_flags[FLAG_Z]   = z_q;
    res_flags[FLAG_OF]  = of_q;
    res_flags[FLAG_SOF] = sof;
  end

  assign res_data = acc_q;
  assign alu_op   = op_q;
  assign alu_in_c = in_c_q;
  assign alu_in_x = in_x_q;
  assign alu_in_y = in_y_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a 4-bit add/sub ALU beside it.
// Sticky-flag expectations follow ALU_SEQ_STICKY_OF_EN.
module tb_alu_seq;

  localparam int unsigned W = 4;
`ifdef ALU_SEQ_STICKY_OF_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         cmd_load;
  logic         cmd_use_carry;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [3:0]   res_flags;
  logic [2:0]   alu_op;
  logic         alu_in_c;
  logic [W-1:0] alu_in_x;
  logic [W-1:0] alu_in_y;
  logic [W-1:0] alu_out_s;
  logic         alu_out_c;
  logic         alu_zero;
  logic         alu_overflow;
  logic [W:0]   sum5;

  int checks   = 0;
  int failures = 0;
  int lat;
  logic         exec_c;
  logic         exec_rv;
  logic [W-1:0] exec_x;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_load     (cmd_load),
    .cmd_use_carry(cmd_use_carry),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_flags    (res_flags),
    .alu_op       (alu_op),
    .alu_in_c     (alu_in_c),
    .alu_in_x     (alu_in_x),
    .alu_in_y     (alu_in_y),
    .alu_out_s    (alu_out_s),
    .alu_out_c    (alu_out_c),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
  );

  // Downstream ALU: op 0 add with carry, op 1 subtract with borrow.
  always_comb begin
    sum5         = '0;
    alu_out_s    = '0;
    alu_out_c    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'd0: begin
        sum5         = {1'b0, alu_in_x} + {1'b0, alu_in_y} + {4'b0, alu_in_c};
        alu_out_s    = sum5[3:0];
        alu_out_c    = sum5[4];
        alu_overflow = (alu_in_x[3] == alu_in_y[3]) && (sum5[3] != alu_in_x[3]);
      end
      3'd1: begin
        sum5         = {1'b0, alu_in_x} - {1'b0, alu_in_y} - {4'b0, alu_in_c};
        alu_out_s    = sum5[3:0];
        alu_out_c    = sum5[4];
        alu_overflow = (alu_in_x[3] != alu_in_y[3]) && (sum5[3] != alu_in_x[3]);
      end
      default: ;
    endcase
    alu_zero = (alu_out_s == '0);
  end

  task automatic do_cmd(input logic ld, input logic [2:0] op, input logic [3:0] d,
                        input logic uc, output int l);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_data = d; cmd_use_carry = uc;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout cmd_ready=%b expected 1", cmd_ready);
      cmd_valid = 1'b0;
      l = -1;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    l = 0;
    do begin
      @(negedge clk);
      l++;
      if (l == 1) begin
        exec_c  = alu_in_c;
        exec_x  = alu_in_x;
        exec_rv = res_valid;
      end
    end while (!res_valid && l < 10);
  endtask

  task automatic finish_res();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, res_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_hs ready/valid=%b expected 00", {cmd_ready, res_valid});
    end
    checks++;
    if ({res_data, res_flags, alu_op, alu_in_c, alu_in_x, alu_in_y} !== '0) begin
      failures++;
      $display("FAIL reset_regs acc=%b flags=%b op=%b c=%b x=%b y=%b expected all 0",
               res_data, res_flags, alu_op, alu_in_c, alu_in_x, alu_in_y);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release cmd_ready=%b expected 1", cmd_ready);
    end
  endtask

  task automatic test_add_overflow();
    do_cmd(1'b1, 3'd0, 4'b0111, 1'b0, lat);
    checks++;
    if (lat !== 1 || res_data !== 4'b0111) begin
      failures++;
      $display("FAIL load_latency lat=%0d data=%b expected 1 0111", lat, res_data);
    end
    finish_res();
    do_cmd(1'b0, 3'd0, 4'b0001, 1'b0, lat);
    checks++;
    if (lat !== 2 || exec_rv !== 1'b0) begin
      failures++;
      $display("FAIL add_latency lat=%0d exec_valid=%b expected 2 0", lat, exec_rv);
    end
    checks++;
    if (exec_x !== 4'b0111) begin
      failures++;
      $display("FAIL add_in_x x=%b expected 0111", exec_x);
    end
    checks++;
    if (res_data !== 4'b1000 || res_flags !== {STICKY, 3'b100}) begin
      failures++;
      $display("FAIL add_ovf data=%b flags=%b expected 1000 %b", res_data, res_flags,
               {STICKY, 3'b100});
    end
    finish_res();
  endtask

  task automatic test_add_carry();
    do_cmd(1'b1, 3'd0, 4'b0011, 1'b0, lat);
    checks++;
    if (res_data !== 4'b0011 || res_flags !== 4'b0100) begin
      failures++;
      $display("FAIL load_keeps_flags data=%b flags=%b expected 0011 0100", res_data, res_flags);
    end
    finish_res();
    do_cmd(1'b0, 3'd0, 4'b1101, 1'b0, lat);
    checks++;
    if (res_data !== 4'b0000 || res_flags !== 4'b0011) begin
      failures++;
      $display("FAIL add_carry data=%b flags=%b expected 0000 0011", res_data, res_flags);
    end
    finish_res();
  endtask

  task automatic test_use_carry();
    do_cmd(1'b0, 3'd0, 4'b0000, 1'b1, lat);
    checks++;
    if (exec_c !== 1'b1) begin
      failures++;
      $display("FAIL use_carry_in alu_in_c=%b expected 1", exec_c);
    end
    checks++;
    if (res_data !== 4'b0001 || res_flags !== 4'b0000) begin
      failures++;
      $display("FAIL use_carry_res data=%b flags=%b expected 0001 0000", res_data, res_flags);
    end
    finish_res();
  endtask

  task automatic test_backpressure();
    do_cmd(1'b1, 3'd0, 4'b1000, 1'b0, lat);
    finish_res();
    do_cmd(1'b0, 3'd1, 4'b0001, 1'b0, lat);
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_data !== 4'b0111 ||
          res_flags !== {STICKY, 3'b100}) begin
        failures++;
        $display("FAIL hold_%0d valid=%b ready=%b data=%b flags=%b expected 1 0 0111 %b",
                 i, res_valid, cmd_ready, res_data, res_flags, {STICKY, 3'b100});
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    finish_res();
    @(negedge clk);
    checks++;
    if (res_data !== 4'b0111 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL no_extra_cmd data=%b ready=%b expected 0111 1", res_data, cmd_ready);
    end
  endtask

  task automatic test_reset_exec();
    do_cmd(1'b1, 3'd0, 4'b0101, 1'b0, lat);
    finish_res();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd0; cmd_data = 4'b0001; cmd_use_carry = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b0 || res_data !== 4'b0000 ||
        res_flags !== 4'b0000 || alu_in_x !== 4'b0000) begin
      failures++;
      $display("FAIL rst_exec valid=%b ready=%b data=%b flags=%b x=%b expected 0 0 0000 0000 0000",
               res_valid, cmd_ready, res_data, res_flags, alu_in_x);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_exec_after ready=%b valid=%b expected 1 0", cmd_ready, res_valid);
    end
  endtask

  task automatic test_sticky();
    do_cmd(1'b1, 3'd0, 4'b0111, 1'b0, lat);
    finish_res();
    do_cmd(1'b0, 3'd0, 4'b0111, 1'b0, lat);
    checks++;
    if (res_data !== 4'b1110 || res_flags !== {STICKY, 3'b100}) begin
      failures++;
      $display("FAIL sticky_set data=%b flags=%b expected 1110 %b", res_data, res_flags,
               {STICKY, 3'b100});
    end
    finish_res();
    do_cmd(1'b0, 3'd0, 4'b0011, 1'b0, lat);
    finish_res();
    do_cmd(1'b0, 3'd0, 4'b0001, 1'b0, lat);
    checks++;
    if (res_data !== 4'b0010 || res_flags !== {STICKY, 3'b000}) begin
      failures++;
      $display("FAIL sticky_hold data=%b flags=%b expected 0010 %b", res_data, res_flags,
               {STICKY, 3'b000});
    end
    finish_res();
    do_cmd(1'b1, 3'd0, 4'b0000, 1'b0, lat);
    checks++;
    if (res_data !== 4'b0000 || res_flags !== 4'b0000) begin
      failures++;
      $display("FAIL sticky_clear data=%b flags=%b expected 0000 0000", res_data, res_flags);
    end
    finish_res();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_load = 1'b0;
    cmd_use_carry = 1'b0; res_ready = 1'b0;
    test_reset();
    test_add_overflow();
    test_add_carry();
    test_use_carry();
    test_backpressure();
    test_reset_exec();
    test_sticky();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
